// File: rtl/biriscv_mem_pkg.sv
// Shared types and the address-range helper for the biRISC-V harness memory arbiter.
package biriscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_LO  = 2'd1,
        I_HI  = 2'd2,
        D_RSP = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // Unsigned subtraction makes addresses below base wrap to a huge offset, i.e. unmapped.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] bytes);
        logic [31:0] offset;
        offset = addr - base;
        return (offset < bytes);
    endfunction

endpackage

// File: rtl/biriscv_rr_arb2.sv
// Two-requester round-robin arbiter (fetch vs data) holding the last-grant history bit.
module biriscv_rr_arb2
    import biriscv_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic req_fetch,
    input  logic req_data,
    output logic grant_fetch,
    output logic grant_data
);

    grant_e last_grant_r;

    // Fetch wins unless data is also requesting and fetch took the previous grant.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (enable) begin
            if (req_fetch && (!req_data || (last_grant_r == GRANT_D))) begin
                grant_fetch = 1'b1;
            end else if (req_data) begin
                grant_data = 1'b1;
            end else begin
                grant_fetch = 1'b0;
                grant_data  = 1'b0;
            end
        end else begin
            grant_fetch = 1'b0;
            grant_data  = 1'b0;
        end
    end

    // History starts at data so fetch wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= GRANT_D;
        end else if (grant_fetch) begin
            last_grant_r <= GRANT_I;
        end else if (grant_data) begin
            last_grant_r <= GRANT_D;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/biriscv_mem_arbiter.sv
// Shares one 32-bit synchronous memory port between the 64-bit fetch port and the tagged data port.
module biriscv_mem_arbiter
    import biriscv_mem_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] MEM_BYTES = 32'h0001_0000,
    parameter int          TAG_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_rd_i,
    input  logic [31:0]      i_pc_i,
    output logic             i_accept_o,
    output logic             i_valid_o,
    output logic [63:0]      i_inst_o,
    output logic             i_error_o,
    input  logic             d_rd_i,
    input  logic [3:0]       d_wr_i,
    input  logic [31:0]      d_addr_i,
    input  logic [31:0]      d_data_wr_i,
    input  logic [TAG_W-1:0] d_req_tag_i,
    output logic             d_accept_o,
    output logic             d_ack_o,
    output logic [31:0]      d_data_rd_o,
    output logic [TAG_W-1:0] d_resp_tag_o,
    output logic             d_error_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_strb_o,
    input  logic [31:0]      mem_rdata_i
);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic [31:0]      pc_r;
    logic [31:0]      lo_r;
    logic [TAG_W-1:0] tag_r;
    logic             write_r;
    logic             err_r;

    logic             arb_en_s;
    logic             d_req_s;
    logic             grant_fetch_s;
    logic             grant_data_s;
    logic             fetch_lo_ok_s;
    logic             fetch_hi_ok_s;
    logic             fetch_err_s;
    logic             data_err_s;
    logic             hi_beat_ok_s;

    assign arb_en_s = (state_r == IDLE) && !rst_i;
    assign d_req_s  = d_rd_i | (|d_wr_i);

    // Base is at least 8-byte aligned, so checking the raw addresses equals checking the aligned ones.
    assign fetch_lo_ok_s = in_range(i_pc_i, MEM_BASE, MEM_BYTES);
    assign fetch_hi_ok_s = in_range({i_pc_i[31:3], 3'b100}, MEM_BASE, MEM_BYTES);
    assign fetch_err_s   = !(fetch_lo_ok_s && fetch_hi_ok_s);
    assign data_err_s    = !in_range(d_addr_i, MEM_BASE, MEM_BYTES);
    assign hi_beat_ok_s  = in_range(pc_r + 32'd4, MEM_BASE, MEM_BYTES);

    biriscv_rr_arb2 u_arb (
        .clk         (clk_i),
        .rst         (rst_i),
        .enable      (arb_en_s),
        .req_fetch   (i_rd_i),
        .req_data    (d_req_s),
        .grant_fetch (grant_fetch_s),
        .grant_data  (grant_data_s)
    );

    // Next state follows the fixed beat sequence of each transaction type.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_fetch_s) begin
                    state_nxt_s = I_LO;
                end else if (grant_data_s) begin
                    state_nxt_s = D_RSP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            I_LO:    state_nxt_s = I_HI;
            I_HI:    state_nxt_s = IDLE;
            D_RSP:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory beats and responses; everything is forced low while reset is held so an aborted
    // transaction can never emit a response.
    always_comb begin
        i_accept_o   = 1'b0;
        i_valid_o    = 1'b0;
        i_inst_o     = 64'd0;
        i_error_o    = 1'b0;
        d_accept_o   = 1'b0;
        d_ack_o      = 1'b0;
        d_data_rd_o  = 32'd0;
        d_resp_tag_o = '0;
        d_error_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 32'd0;
        mem_wdata_o  = 32'd0;
        mem_strb_o   = 4'd0;
        if (!rst_i) begin
            case (state_r)
                IDLE: begin
                    if (grant_fetch_s) begin
                        i_accept_o = 1'b1;
                        if (fetch_lo_ok_s) begin
                            mem_req_o  = 1'b1;
                            mem_addr_o = {i_pc_i[31:3], 3'b000};
                        end else begin
                            mem_req_o  = 1'b0;
                        end
                    end else if (grant_data_s) begin
                        d_accept_o = 1'b1;
                        if (!data_err_s) begin
                            mem_req_o   = 1'b1;
                            mem_we_o    = |d_wr_i;
                            mem_addr_o  = {d_addr_i[31:2], 2'b00};
                            mem_wdata_o = d_data_wr_i;
                            mem_strb_o  = d_wr_i;
                        end else begin
                            mem_req_o   = 1'b0;
                        end
                    end else begin
                        mem_req_o = 1'b0;
                    end
                end
                I_LO: begin
                    if (hi_beat_ok_s) begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = pc_r + 32'd4;
                    end else begin
                        mem_req_o  = 1'b0;
                    end
                end
                I_HI: begin
                    i_valid_o = 1'b1;
                    i_error_o = err_r;
                    if (err_r) begin
                        i_inst_o = 64'd0;
                    end else begin
                        i_inst_o = {mem_rdata_i, lo_r};
                    end
                end
                D_RSP: begin
                    d_ack_o      = 1'b1;
                    d_resp_tag_o = tag_r;
                    d_error_o    = err_r;
                    if (err_r || write_r) begin
                        d_data_rd_o = 32'd0;
                    end else begin
                        d_data_rd_o = mem_rdata_i;
                    end
                end
                default: begin
                    mem_req_o = 1'b0;
                end
            endcase
        end else begin
            mem_req_o = 1'b0;
        end
    end

    // Transaction context captured at grant time, low fetch word captured one beat later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            pc_r    <= 32'd0;
            lo_r    <= 32'd0;
            tag_r   <= '0;
            write_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_fetch_s) begin
                pc_r  <= {i_pc_i[31:3], 3'b000};
                err_r <= fetch_err_s;
            end else if (grant_data_s) begin
                tag_r   <= d_req_tag_i;
                write_r <= |d_wr_i;
                err_r   <= data_err_s;
            end
            if (state_r == I_LO) begin
                lo_r <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_biriscv_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, memory beats and responses.
module tb_biriscv_mem_arbiter;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] BYTES = 32'h0001_0000;
    localparam int          TW    = 11;
    localparam int          WORDS = 16384;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          i_rd_i = 1'b0;
    logic [31:0]   i_pc_i = 32'd0;
    logic          d_rd_i = 1'b0;
    logic [3:0]    d_wr_i = 4'd0;
    logic [31:0]   d_addr_i = 32'd0;
    logic [31:0]   d_data_wr_i = 32'd0;
    logic [TW-1:0] d_req_tag_i = '0;
    logic [31:0]   mem_rdata_i = 32'd0;
    logic          i_accept_o, i_valid_o, i_error_o;
    logic [63:0]   i_inst_o;
    logic          d_accept_o, d_ack_o, d_error_o;
    logic [31:0]   d_data_rd_o;
    logic [TW-1:0] d_resp_tag_o;
    logic          mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o, mem_wdata_o;
    logic [3:0]    mem_strb_o;

    biriscv_mem_arbiter #(.MEM_BASE(BASE), .MEM_BYTES(BYTES), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_rd_i(i_rd_i), .i_pc_i(i_pc_i), .i_accept_o(i_accept_o), .i_valid_o(i_valid_o),
        .i_inst_o(i_inst_o), .i_error_o(i_error_o),
        .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_data_wr_i(d_data_wr_i),
        .d_req_tag_i(d_req_tag_i), .d_accept_o(d_accept_o), .d_ack_o(d_ack_o),
        .d_data_rd_o(d_data_rd_o), .d_resp_tag_o(d_resp_tag_o), .d_error_o(d_error_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } beat_t;
    typedef struct { int cyc; logic is_d; logic [63:0] data; logic [TW-1:0] tag; logic err; } resp_t;
    typedef struct { int cyc; logic is_d; } grant_t;

    beat_t  beat_q[$];
    resp_t  resp_q[$];
    grant_t glog[$];

    logic [31:0] ram[WORDS];
    logic [31:0] ref_mem[WORDS];
    logic        ram_init = 1'b0;

    int n_pass = 0, n_total = 0, cyc = 0, free_at = 0;
    logic last_d = 1'b1, rst_req = 1'b1, rand_mode = 1'b0, keep_both = 1'b0, log_en = 1'b0;
    logic i_pend = 1'b0, d_pend = 1'b0, d_rd = 1'b0, saw_gi = 1'b0;
    logic [31:0] pc = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
    logic [3:0]  d_wr = 4'd0;
    logic [TW-1:0] d_tag = '0;

    function automatic logic [31:0] pattern(input int k);
        if (k == 0) return 32'h1111_1111;
        if (k == 1) return 32'h2222_2222;
        return (k * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < BYTES;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[15:2]);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Memory model: one-cycle read latency, byte-strobed writes, garbage when not read.
    always @(posedge clk) begin
        logic [31:0] w;
        if (!ram_init) begin
            for (int k = 0; k < WORDS; k++) ram[k] = pattern(k);
            ram_init = 1'b1;
        end
        if (mem_req_o && mem_we_o) begin
            w = ram[mem_addr_o[15:2]];
            for (int b = 0; b < 4; b++) if (mem_strb_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
            ram[mem_addr_o[15:2]] = w;
            mem_rdata_i <= $urandom;
        end else if (mem_req_o) begin
            mem_rdata_i <= ram[mem_addr_o[15:2]];
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) return ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + BYTES;
        if (r == 2) return BASE + BYTES - 32'($urandom_range(1, 8));
        return BASE + 32'h100 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
    endfunction

    task automatic new_data();
        d_pend  = 1'b1;
        d_wr    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        d_rd    = (d_wr == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = $urandom;
        d_tag   = TW'($urandom);
    endtask

    // Transaction-level prediction for the cycle just driven.
    task automatic predict();
        logic gi, gd;
        logic [31:0] a;
        logic err, wr;
        gi = 1'b0; gd = 1'b0;
        if (rst_i) begin
            beat_q.delete(); resp_q.delete();
            free_at = cyc + 1; last_d = 1'b1;
        end else begin
            gi = (cyc >= free_at) && i_pend && (!d_pend || last_d);
            gd = (cyc >= free_at) && d_pend && !gi;
        end
        check("accept", 128'({i_accept_o, d_accept_o}), 128'({gi, gd}));
        if (gi) begin
            a = {pc[31:3], 3'b000};
            err = !(mapped(a) && mapped(a + 32'd4));
            if (mapped(a)) beat_q.push_back('{cyc, 1'b0, a, 32'd0, 4'd0});
            if (mapped(a + 32'd4)) beat_q.push_back('{cyc + 1, 1'b0, a + 32'd4, 32'd0, 4'd0});
            resp_q.push_back('{cyc + 2, 1'b0,
                err ? 64'd0 : {ref_mem[widx(a + 32'd4)], ref_mem[widx(a)]}, '0, err});
            free_at = cyc + 3; last_d = 1'b0; i_pend = 1'b0; saw_gi = 1'b1;
            if (log_en) glog.push_back('{cyc, 1'b0});
        end
        if (gd) begin
            a = {d_addr[31:2], 2'b00};
            err = !mapped(a);
            wr = (d_wr != 4'd0);
            if (!err) begin
                beat_q.push_back('{cyc, wr, a, d_wdata, d_wr});
                for (int b = 0; b < 4; b++)
                    if (d_wr[b]) ref_mem[widx(a)][8*b +: 8] = d_wdata[8*b +: 8];
            end
            resp_q.push_back('{cyc + 1, 1'b1, (err || wr) ? 64'd0 : {32'd0, ref_mem[widx(a)]}, d_tag, err});
            free_at = cyc + 2; last_d = 1'b1; d_pend = 1'b0;
            if (log_en) glog.push_back('{cyc, 1'b1});
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (rand_mode || keep_both) begin
            if (!i_pend && (keep_both || $urandom_range(0, 2) == 0)) begin i_pend = 1'b1; pc = rand_addr(); end
            if (!d_pend && (keep_both || $urandom_range(0, 2) == 0)) new_data();
        end
        rst_i       = rst_req;
        i_rd_i      = i_pend;
        i_pc_i      = i_pend ? pc : $urandom;
        d_rd_i      = d_pend ? d_rd : 1'b0;
        d_wr_i      = d_pend ? d_wr : 4'd0;
        d_addr_i    = d_addr;
        d_data_wr_i = d_wdata;
        d_req_tag_i = d_tag;
        @(negedge clk);
        predict();
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (i_pend || d_pend || beat_q.size() != 0 || resp_q.size() != 0); k++) step();
        check("drain", 128'({i_pend, d_pend, beat_q.size() == 0, resp_q.size() == 0}), 128'(4'b0011));
    endtask

    // Monitor: compares every memory beat and response against the scoreboard queues.
    initial begin
        beat_t b;
        resp_t r;
        forever begin
            @(negedge clk); #1;
            if (beat_q.size() != 0 && beat_q[0].cyc == cyc) begin
                b = beat_q.pop_front();
                check("mem_beat", 128'({mem_req_o, mem_we_o, mem_strb_o, mem_addr_o, mem_wdata_o}),
                      128'({1'b1, b.we, b.strb, b.addr, b.wdata}));
            end else begin
                check("mem_idle", 128'({mem_req_o, mem_we_o, mem_strb_o, mem_addr_o, mem_wdata_o}), 128'd0);
            end
            if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
                r = resp_q.pop_front();
                if (r.is_d) begin
                    check("d_resp", 128'({i_valid_o, i_error_o, i_inst_o, d_ack_o, d_error_o, d_data_rd_o, d_resp_tag_o}),
                          128'({1'b0, 1'b0, 64'd0, 1'b1, r.err, r.data[31:0], r.tag}));
                end else begin
                    check("i_resp", 128'({i_valid_o, i_error_o, i_inst_o, d_ack_o, d_error_o, d_data_rd_o}),
                          128'({1'b1, r.err, r.data, 1'b0, 1'b0, 32'd0}));
                end
            end else begin
                check("resp_idle", 128'({i_valid_o, i_error_o, i_inst_o, d_ack_o, d_error_o, d_data_rd_o}), 128'd0);
            end
        end
    end

    initial begin
        int t0;
        for (int k = 0; k < WORDS; k++) ref_mem[k] = pattern(k);
        repeat (3) step();
        rst_req = 1'b0;

        // Both ports requesting continuously straight out of reset.
        log_en = 1'b1; keep_both = 1'b1;
        t0 = cyc + 1;
        repeat (12) step();
        keep_both = 1'b0; log_en = 1'b0;
        drain();
        check("grant_order", 128'({glog[0].is_d, glog[1].is_d, glog[2].is_d, glog[3].is_d}), 128'(4'b0101));
        check("grant_cycles", 128'({glog[0].cyc - t0, glog[1].cyc - t0, glog[2].cyc - t0, glog[3].cyc - t0}),
              128'({32'd0, 32'd3, 32'd5, 32'd8}));

        // Directed fetch, read, strobed write with read ignored, read-back.
        i_pend = 1'b1; pc = 32'h8000_0004; drain();
        d_pend = 1'b1; d_rd = 1'b1; d_wr = 4'd0; d_addr = 32'h8000_0102; d_tag = 11'h05A; drain();
        d_pend = 1'b1; d_rd = 1'b1; d_wr = 4'b0011; d_addr = 32'h8000_0200; d_wdata = 32'hDEAD_BEEF; d_tag = 11'h123; drain();
        d_pend = 1'b1; d_rd = 1'b1; d_wr = 4'd0; d_addr = 32'h8000_0200; d_tag = 11'h7FF; drain();

        // Unmapped data read below base and fetch past the top.
        d_pend = 1'b1; d_rd = 1'b1; d_wr = 4'd0; d_addr = 32'h7FFF_FFFC; d_tag = 11'h011;
        i_pend = 1'b1; pc = 32'h8001_0000; drain();

        // Reset asserted while the fetch sits in I_HI.
        saw_gi = 1'b0; i_pend = 1'b1; pc = 32'h8000_0008;
        for (int k = 0; k < 10 && !saw_gi; k++) step();
        check("reset_fetch_accepted", 128'(saw_gi), 128'(1'b1));
        step();
        rst_req = 1'b1; step();
        rst_req = 1'b0; i_pend = 1'b1; pc = 32'h8000_0010; step();
        check("accept_after_reset", 128'(i_accept_o), 128'(1'b1));
        drain();

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
